// File: rtl/tis_pkg.sv
// Shared TIS grid definitions: port/operand ids, opcode fields, loader command/error/state enums.
package tis_pkg;

  localparam logic [2:0] NIL   = 3'd0;
  localparam logic [2:0] ACC   = 3'd1;
  localparam logic [2:0] ANY   = 3'd2;
  localparam logic [2:0] LAST  = 3'd3;
  localparam logic [2:0] LEFT  = 3'd4;
  localparam logic [2:0] RIGHT = 3'd5;
  localparam logic [2:0] UP    = 3'd6;
  localparam logic [2:0] DOWN  = 3'd7;

  // Instruction word: [15:12] opcode, [11:9] src, [8:6] dst, [5:0] immediate/target
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_SWP = 4'd2;
  localparam logic [3:0] OP_SAV = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JEZ = 4'd8;
  localparam logic [3:0] OP_JNZ = 4'd9;
  localparam logic [3:0] OP_JGZ = 4'd10;
  localparam logic [3:0] OP_JLZ = 4'd11;
  localparam logic [3:0] OP_JRO = 4'd12;

  localparam int MAX_LEN = 15;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_HALT = 2'd2,
    CMD_RSVD = 2'd3
  } loaderCmd_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_NODE = 2'd2,
    ERR_CSUM = 2'd3
  } loaderErr_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CSUM    = 3'd2,
    COMMIT  = 3'd3,
    DISCARD = 3'd4
  } loaderState_e;

endpackage

// File: rtl/tis_prog_loader.sv
// Host-side program loader for the TIS node grid: writes program stores, commits lengths, gates core reset.
// Optional trailing XOR checksum word enabled by defining TIS_LOADER_CSUM_EN.
module tis_prog_loader
  import tis_pkg::*;
#(
  parameter  int NODES  = 12,
  localparam int NODE_W = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic              prog_we,
  output logic [NODE_W-1:0] prog_node,
  output logic [3:0]        prog_addr,
  output logic [15:0]       prog_data,
  output logic              plen_we,
  output logic [3:0]        plen_data,
  output logic              core_rst,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              err_clr
);

  localparam logic [6:0] NODES7 = 7'(NODES);

  loaderState_e state;
  logic         started;
  logic [3:0]   len, cnt;
`ifdef TIS_LOADER_CSUM_EN
  logic [15:0]  csum;
  logic         dropping;
`endif

  loaderCmd_e   hdrCmd;
  logic [5:0]   hdrNode;
  logic [3:0]   hdrLen;
  logic         xfer, lastWord;
  logic         unusedHdrBits;

  assign hdrCmd        = loaderCmd_e'(in_data[15:14]);
  assign hdrNode       = in_data[13:8];
  assign hdrLen        = in_data[3:0];
  assign unusedHdrBits = ^in_data[7:4];

  // Ready drops for the single cycle after reset and for the COMMIT bubble only.
  assign in_ready = started && (state != COMMIT);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign lastWord = (cnt == len - 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      started   <= 1'b0;
      core_rst  <= 1'b1;
      prog_we   <= 1'b0;
      prog_node <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      plen_we   <= 1'b0;
      plen_data <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      len       <= '0;
      cnt       <= '0;
`ifdef TIS_LOADER_CSUM_EN
      csum      <= '0;
      dropping  <= 1'b0;
`endif
    end else begin
      started <= 1'b1;
      prog_we <= 1'b0;
      plen_we <= 1'b0;
      // A clear is overridden by any error raised below in the same cycle.
      if (err_clr) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
      case (state)
        IDLE: if (xfer) begin
          case (hdrCmd)
            CMD_LOAD: begin
              core_rst <= 1'b1;
              len      <= hdrLen;
              cnt      <= '0;
`ifdef TIS_LOADER_CSUM_EN
              csum     <= in_data;
              dropping <= 1'b0;
`endif
              if (hdrLen == 4'd0) begin
                err      <= 1'b1;
                err_code <= ERR_LEN;
              end else if ({1'b0, hdrNode} >= NODES7) begin
                err      <= 1'b1;
                err_code <= ERR_NODE;
                state    <= DISCARD;
              end else begin
                prog_node <= hdrNode[NODE_W-1:0];
                state     <= LOAD;
              end
            end
            CMD_RUN:  core_rst <= 1'b0;
            CMD_HALT: core_rst <= 1'b1;
            default:  ;
          endcase
        end
        LOAD: if (xfer) begin
          prog_we   <= 1'b1;
          prog_addr <= cnt;
          prog_data <= in_data;
          cnt       <= cnt + 4'd1;
`ifdef TIS_LOADER_CSUM_EN
          csum      <= csum ^ in_data;
          if (lastWord) state <= CSUM;
`else
          if (lastWord) state <= COMMIT;
`endif
        end
`ifdef TIS_LOADER_CSUM_EN
        CSUM: if (xfer) begin
          if (dropping) begin
            state <= IDLE;
          end else if (in_data == csum) begin
            state <= COMMIT;
          end else begin
            err      <= 1'b1;
            err_code <= ERR_CSUM;
            state    <= IDLE;
          end
        end
`endif
        COMMIT: begin
          plen_we   <= 1'b1;
          plen_data <= len;
          state     <= IDLE;
        end
        DISCARD: if (xfer) begin
          cnt <= cnt + 4'd1;
          if (lastWord) begin
`ifdef TIS_LOADER_CSUM_EN
            dropping <= 1'b1;
            state    <= CSUM;
`else
            state    <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tis_prog_loader.sv
// Self-checking bench for tis_prog_loader: command table, hand sequences and randomized loads vs a stream model.
module tb_tis_prog_loader;

  localparam int NODES = 12;
  localparam int NW    = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          in_valid = 0;
  logic [15:0]   in_data = '0;
  logic          in_ready;
  logic          prog_we;
  logic [NW-1:0] prog_node;
  logic [3:0]    prog_addr;
  logic [15:0]   prog_data;
  logic          plen_we;
  logic [3:0]    plen_data;
  logic          core_rst;
  logic          busy;
  logic          err;
  logic [1:0]    err_code;
  logic          err_clr = 0;

  tis_prog_loader #(.NODES(NODES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .prog_we(prog_we), .prog_node(prog_node), .prog_addr(prog_addr), .prog_data(prog_data),
    .plen_we(plen_we), .plen_data(plen_data), .core_rst(core_rst), .busy(busy),
    .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] node; logic [3:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [5:0] node; logic [3:0] len; } pl_t;

  wr_t wrQ[$];
  pl_t plQ[$];

  always @(negedge clk) begin
    if (prog_we) wrQ.push_back('{node: 6'(prog_node), addr: prog_addr, data: prog_data});
    if (plen_we) plQ.push_back('{node: 6'(prog_node), len: plen_data});
  end

  int nTests = 0;
  int nFail  = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Model state: what the host should observe from the spec's command rules
  logic [1:0] mErr     = 2'd0;
  logic       mCoreRst = 1'b1;

  task automatic sendWord(input logic [15:0] w, input int gap);
    int budget;
    in_valid = 0;
    repeat (gap) @(negedge clk);
    in_valid = 1;
    in_data  = w;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      nTests++;
      nFail++;
      $display("FAIL sendTimeout: in_ready stuck at 0 for word %0h", w);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic runCmd(input logic [15:0] hdr, input logic [15:0] w[16], input bit corrupt,
                        input int maxGap, output int nWr, output int nPl);
    wr_t exW[$];
    pl_t exP[$];
    logic [1:0]  cmd;
    logic [5:0]  node;
    int          len;
    logic [15:0] x;
    bit          good;
    cmd  = hdr[15:14];
    node = hdr[13:8];
    len  = int'(hdr[3:0]);
    x    = hdr;
    sendWord(hdr, $urandom_range(0, maxGap));
    if (cmd == 2'd0) begin
      mCoreRst = 1'b1;
      chk("coreRstOnHeader", core_rst, 1);
      if (len == 0) mErr = 2'd1;
      else begin
        good = (int'(node) < NODES);
        if (!good) mErr = 2'd2;
        for (int i = 0; i < len; i++) begin
          sendWord(w[i], $urandom_range(0, maxGap));
          x ^= w[i];
          if (good) exW.push_back('{node: node, addr: 4'(i), data: w[i]});
        end
`ifdef TIS_LOADER_CSUM_EN
        sendWord(corrupt ? (x ^ 16'h0100) : x, $urandom_range(0, maxGap));
        if (good && corrupt) mErr = 2'd3;
        if (good && !corrupt) exP.push_back('{node: node, len: 4'(len)});
`else
        if (good) exP.push_back('{node: node, len: 4'(len)});
`endif
      end
    end else if (cmd == 2'd1) mCoreRst = 1'b0;
    else if (cmd == 2'd2) mCoreRst = 1'b1;
    repeat (4) @(negedge clk);
    nWr = wrQ.size();
    nPl = plQ.size();
    chk("wrCount", nWr, exW.size());
    for (int i = 0; i < nWr && i < exW.size(); i++) chk("wrEntry", wrQ[i], exW[i]);
    chk("plCount", nPl, exP.size());
    for (int i = 0; i < nPl && i < exP.size(); i++) chk("plEntry", plQ[i], exP[i]);
    chk("idleAfterCmd", busy, 0);
    wrQ.delete();
    plQ.delete();
  endtask

  typedef struct {
    logic [15:0] hdr;
    logic [15:0] w[4];
    logic [1:0]  expCode;
    int          expWr;
    int          expPl;
    logic        expCoreRst;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [15:0] wb[16];
    int nWr, nPl;

    tbl[0]  = '{16'h0102, '{16'h4ABC, 16'h7FFF, 16'h0, 16'h0}, 2'd0, 2, 1, 1'b1};
    tbl[1]  = '{16'h4000, '{16'h0, 16'h0, 16'h0, 16'h0},       2'd0, 0, 0, 1'b0};
    tbl[2]  = '{16'h0001, '{16'h1234, 16'h0, 16'h0, 16'h0},    2'd0, 1, 1, 1'b1};
    tbl[3]  = '{16'h3F03, '{16'h0001, 16'h0002, 16'h0003, 16'h0}, 2'd2, 0, 0, 1'b1};
    tbl[4]  = '{16'h0003, '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0}, 2'd2, 3, 1, 1'b1};
    tbl[5]  = '{16'h0100, '{16'h0, 16'h0, 16'h0, 16'h0},       2'd1, 0, 0, 1'b1};
    tbl[6]  = '{16'hC000, '{16'h0, 16'h0, 16'h0, 16'h0},       2'd1, 0, 0, 1'b1};
    tbl[7]  = '{16'h4000, '{16'h0, 16'h0, 16'h0, 16'h0},       2'd1, 0, 0, 1'b0};
    tbl[8]  = '{16'h4000, '{16'h0, 16'h0, 16'h0, 16'h0},       2'd1, 0, 0, 1'b0};
    tbl[9]  = '{16'h8000, '{16'h0, 16'h0, 16'h0, 16'h0},       2'd1, 0, 0, 1'b1};
    tbl[10] = '{16'h0B01, '{16'hBEEF, 16'h0, 16'h0, 16'h0},    2'd1, 1, 1, 1'b1};
    tbl[11] = '{16'h0C01, '{16'h0042, 16'h0, 16'h0, 16'h0},    2'd2, 0, 0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rstCoreRst", core_rst, 1);
    chk("rstBusy", busy, 0);
    chk("rstErr", err, 0);
    chk("rstErrCode", err_code, 0);
    chk("rstReady", in_ready, 0);
    chk("rstProgWe", prog_we, 0);
    chk("rstPlenWe", plen_we, 0);
    chk("rstAddr", prog_addr, 0);
    rst = 0;
    #1 chk("readyFirstCycle", in_ready, 0);
    @(negedge clk);
    chk("readyAfterFirst", in_ready, 1);

    // Table of commands
    foreach (tbl[t]) begin
      for (int i = 0; i < 16; i++) wb[i] = (i < 4) ? tbl[t].w[i] : 16'h0;
      runCmd(tbl[t].hdr, wb, 1'b0, 0, nWr, nPl);
      chk($sformatf("tbl%0d_errCode", t), err_code, tbl[t].expCode);
      chk($sformatf("tbl%0d_err", t), err, tbl[t].expCode != 2'd0);
      chk($sformatf("tbl%0d_nWr", t), nWr, tbl[t].expWr);
      chk($sformatf("tbl%0d_nPl", t), nPl, tbl[t].expPl);
      chk($sformatf("tbl%0d_coreRst", t), core_rst, tbl[t].expCoreRst);
    end

    // err_clr pulse clears on the next edge
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("errClr_err", err, 0);
    chk("errClr_code", err_code, 0);
    mErr = 2'd0;

    // Full 15-word load with random valid gaps
    for (int i = 0; i < 16; i++) wb[i] = 16'($urandom);
    runCmd(16'h050F, wb, 1'b0, 3, nWr, nPl);
    chk("len15_nWr", nWr, 15);
    chk("len15_nPl", nPl, 1);
    chk("len15_err", err_code, 0);

`ifdef TIS_LOADER_CSUM_EN
    // Corrupted checksum: words still written, no length commit
    runCmd(16'h0203, wb, 1'b1, 0, nWr, nPl);
    chk("csumBad_code", err_code, 3);
    chk("csumBad_nPl", nPl, 0);
    chk("csumBad_nWr", nWr, 3);
`endif

    // Randomized commands against the model
    for (int r = 0; r < 30; r++) begin
      logic [15:0] hdr;
      int sel;
      sel = $urandom_range(0, 9);
      hdr = {(sel < 7) ? 2'd0 : 2'($urandom_range(1, 3)), 6'($urandom_range(0, 15)),
             4'h0, 4'($urandom_range(0, 15))};
      for (int i = 0; i < 16; i++) wb[i] = 16'($urandom);
      runCmd(hdr, wb, ($urandom_range(0, 3) == 0), 2, nWr, nPl);
      chk("rnd_errCode", err_code, mErr);
      chk("rnd_err", err, mErr != 2'd0);
      chk("rnd_coreRst", core_rst, mCoreRst);
    end

    // Reset in the middle of a load: no length commit, clean state
    wrQ.delete();
    plQ.delete();
    sendWord(16'h0203, 0);
    sendWord(16'h1111, 0);
    rst = 1;
    #1;
    chk("midRst_ready", in_ready, 0);
    chk("midRst_busy", busy, 0);
    chk("midRst_coreRst", core_rst, 1);
    chk("midRst_err", err, 0);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("midRst_nPl", plQ.size(), 0);
    chk("midRst_nWr", wrQ.size(), 1);
    chk("midRst_ready2", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
